// File: rtl/i2c_pkg.sv
// Shared types for the I2C slave byte sequencer: SDA mode select, controller
// states and the default byte length.
package i2c_pkg;

   localparam int unsigned BYTE_BITS_DEF = 8;

   typedef enum logic [1:0] {
      SDA_IDLE = 2'b00,
      SDA_ACK  = 2'b01,
      SDA_NACK = 2'b10,
      SDA_TX   = 2'b11
   } sda_mode_t;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_CHK,
      ST_ACK_SLOT,
      ST_NACK_SLOT,
      ST_RX_BYTE,
      ST_TX_BYTE,
      ST_MACK,
      ST_WAIT_STOP
   } ctrl_state_t;

   // SDA output selector setting implied by each controller state
   function automatic sda_mode_t mode_of(input ctrl_state_t s);
      case (s)
         ST_ACK_SLOT:  return SDA_ACK;
         ST_NACK_SLOT: return SDA_NACK;
         ST_TX_BYTE:   return SDA_TX;
         default:      return SDA_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/i2c_bit_counter.sv
// Saturating bit counter with synchronous clear; term_c flags a full byte.
module i2c_bit_counter #(
   parameter int unsigned BYTE_BITS = 8,
   parameter int unsigned CNT_W     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             count_en,
   output logic [CNT_W-1:0] cnt,
   output logic             term_c
);

   assign term_c = (cnt == CNT_W'(BYTE_BITS));

   // Count enabled SCL rises, holding at BYTE_BITS instead of wrapping
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (count_en && !term_c) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C slave byte sequencer: START/STOP framing, address match, ACK/NACK slot
// control and Mealy strobes to the RX/TX shift registers and FIFOs.
// Optional: define I2C_GENERAL_CALL_EN to also acknowledge address byte 0x00.
module i2c_slave_ctrl
   import i2c_pkg::*;
#(
   parameter logic [6:0]  SLAVE_ADDR = 7'h3C,
   parameter int unsigned BYTE_BITS  = BYTE_BITS_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_found,
   input  logic       stop_found,
   input  logic       scl_rise,
   input  logic       scl_fall,
   input  logic       sda_in,
   input  logic [7:0] rx_data,
   input  logic       tx_empty,
   input  logic       rx_full,
   output logic [1:0] sda_mode,
   output logic       rx_shift,
   output logic       tx_shift,
   output logic       load_data,
   output logic       tx_read,
   output logic       rx_write,
   output logic       busy
);

   localparam int unsigned CNT_W = 4;

   ctrl_state_t      state, state_nxt;
   logic             rw;
   logic             mack_nack;
   logic [CNT_W-1:0] bit_cnt;
   logic             cnt_tc;
   logic             cnt_clear;
   logic             cnt_en;
   logic             live;
   logic             rise;
   logic             fall;
   logic             addr_match;

   // SCL edges only count when no reset or framing event overrides them;
   // a fall coinciding with a rise is dropped
   assign live = !rst && !start_found && !stop_found;
   assign rise = live && scl_rise;
   assign fall = live && scl_fall && !scl_rise;

`ifdef I2C_GENERAL_CALL_EN
   assign addr_match = (rx_data[7:1] == SLAVE_ADDR) || (rx_data == 8'h00);
`else
   assign addr_match = (rx_data[7:1] == SLAVE_ADDR);
`endif

   i2c_bit_counter #(
      .BYTE_BITS (BYTE_BITS),
      .CNT_W     (CNT_W)
   ) u_bit_counter (
      .clk      (clk),
      .rst      (rst),
      .clear    (cnt_clear),
      .count_en (cnt_en),
      .cnt      (bit_cnt),
      .term_c   (cnt_tc)
   );

   // Next state, counter control and same-cycle strobes
   always_comb begin
      state_nxt = state;
      rx_shift  = 1'b0;
      tx_shift  = 1'b0;
      load_data = 1'b0;
      tx_read   = 1'b0;
      rx_write  = 1'b0;
      cnt_clear = 1'b0;
      cnt_en    = 1'b0;
      if (stop_found) begin
         state_nxt = ST_IDLE;
         cnt_clear = 1'b1;
      end else if (start_found) begin
         state_nxt = ST_ADDR;
         cnt_clear = 1'b1;
      end else begin
         unique case (state)
            ST_ADDR: begin
               if (rise) begin
                  rx_shift = 1'b1;
                  cnt_en   = 1'b1;
                  if (bit_cnt == CNT_W'(BYTE_BITS - 1)) state_nxt = ST_ADDR_CHK;
               end
            end
            ST_ADDR_CHK: begin
               cnt_clear = 1'b1;
               if (fall) state_nxt = addr_match ? ST_ACK_SLOT : ST_NACK_SLOT;
            end
            ST_ACK_SLOT: begin
               if (fall) begin
                  if (rw) begin
                     state_nxt = ST_TX_BYTE;
                     load_data = 1'b1;
                     tx_read   = !tx_empty;
                  end else begin
                     state_nxt = ST_RX_BYTE;
                  end
               end
            end
            ST_NACK_SLOT: begin
               if (fall) state_nxt = ST_WAIT_STOP;
            end
            ST_RX_BYTE: begin
               if (rise) begin
                  rx_shift = 1'b1;
                  cnt_en   = 1'b1;
               end else if (fall && cnt_tc) begin
                  cnt_clear = 1'b1;
                  if (!rx_full) begin
                     rx_write  = 1'b1;
                     state_nxt = ST_ACK_SLOT;
                  end else begin
                     state_nxt = ST_NACK_SLOT;
                  end
               end
            end
            ST_TX_BYTE: begin
               if (rise) begin
                  cnt_en = 1'b1;
               end else if (fall) begin
                  if (cnt_tc) begin
                     state_nxt = ST_MACK;
                     cnt_clear = 1'b1;
                  end else if (bit_cnt != '0) begin
                     tx_shift = 1'b1;
                  end
               end
            end
            ST_MACK: begin
               if (fall) begin
                  if (!mack_nack) begin
                     state_nxt = ST_TX_BYTE;
                     load_data = 1'b1;
                     tx_read   = !tx_empty;
                  end else begin
                     state_nxt = ST_WAIT_STOP;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // State register with registered Moore outputs and latched transfer context
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         sda_mode  <= 2'(SDA_IDLE);
         busy      <= 1'b0;
         rw        <= 1'b0;
         mack_nack <= 1'b0;
      end else begin
         state    <= state_nxt;
         sda_mode <= 2'(mode_of(state_nxt));
         busy     <= (state_nxt != ST_IDLE);
         if (state == ST_ADDR_CHK) rw <= rx_data[0];
         if (state == ST_MACK && rise) mack_nack <= sda_in;
      end
   end

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Self-checking bench for i2c_slave_ctrl: protocol-level transaction model
// predicts strobes and SDA mode for every cycle; directed and random traffic.
module tb_i2c_slave_ctrl;

`ifdef I2C_GENERAL_CALL_EN
   localparam bit GC_EN = 1'b1;
`else
   localparam bit GC_EN = 1'b0;
`endif

   localparam logic [1:0] M_IDLE = 2'b00;
   localparam logic [1:0] M_ACK  = 2'b01;
   localparam logic [1:0] M_NACK = 2'b10;
   localparam logic [1:0] M_TX   = 2'b11;
   // strobe vector {rx_shift, tx_shift, load_data, tx_read, rx_write}
   localparam logic [4:0] S_NONE = 5'b00000;
   localparam logic [4:0] S_RX   = 5'b10000;
   localparam logic [4:0] S_TX   = 5'b01000;
   localparam logic [4:0] S_LD   = 5'b00100;
   localparam logic [4:0] S_RD   = 5'b00010;
   localparam logic [4:0] S_WR   = 5'b00001;

   logic       clk;
   logic       rst;
   logic       start_found;
   logic       stop_found;
   logic       scl_rise;
   logic       scl_fall;
   logic       sda_in;
   logic [7:0] rx_data;
   logic       tx_empty;
   logic       rx_full;
   logic [1:0] sda_mode;
   logic       rx_shift;
   logic       tx_shift;
   logic       load_data;
   logic       tx_read;
   logic       rx_write;
   logic       busy;

   logic [4:0] exp_strb;
   logic [1:0] exp_mode;
   logic       exp_busy;
   bit         checking = 1'b0;
   int         n_checks = 0;
   int         n_errors = 0;
   int         cnt_rxs  = 0;
   int         cnt_txs  = 0;
   int         cnt_ld   = 0;
   int         cnt_rd   = 0;
   int         cnt_wr   = 0;

   i2c_slave_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .start_found (start_found),
      .stop_found  (stop_found),
      .scl_rise    (scl_rise),
      .scl_fall    (scl_fall),
      .sda_in      (sda_in),
      .rx_data     (rx_data),
      .tx_empty    (tx_empty),
      .rx_full     (rx_full),
      .sda_mode    (sda_mode),
      .rx_shift    (rx_shift),
      .tx_shift    (tx_shift),
      .load_data   (load_data),
      .tx_read     (tx_read),
      .rx_write    (rx_write),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model; inputs change just after posedge
   always @(negedge clk) begin
      if (checking) begin
         chk("sda_mode", 32'(sda_mode), 32'(exp_mode));
         chk("busy", 32'(busy), 32'(exp_busy));
         chk("strobes", 32'({rx_shift, tx_shift, load_data, tx_read, rx_write}), 32'(exp_strb));
         cnt_rxs += int'(rx_shift);
         cnt_txs += int'(tx_shift);
         cnt_ld  += int'(load_data);
         cnt_rd  += int'(tx_read);
         cnt_wr  += int'(rx_write);
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   task automatic gap();
      int n;
      n = $urandom_range(1, 3);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One input event cycle with its expected strobes and the resulting mode/busy
   task automatic ev(input bit st, input bit sp, input bit r, input bit f, input bit sda,
                     input logic [4:0] strb, input logic [1:0] mode_after, input bit busy_after);
      start_found = st;
      stop_found  = sp;
      scl_rise    = r;
      scl_fall    = f;
      sda_in      = sda;
      exp_strb    = strb;
      @(posedge clk);
      #1;
      start_found = 1'b0;
      stop_found  = 1'b0;
      scl_rise    = 1'b0;
      scl_fall    = 1'b0;
      exp_strb    = S_NONE;
      exp_mode    = mode_after;
      exp_busy    = busy_after;
      if (r && strb[4]) rx_data = {rx_data[6:0], sda};
      gap();
   endtask

   task automatic do_start();
      ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, S_NONE, M_IDLE, 1'b1);
   endtask

   task automatic do_stop();
      ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, S_NONE, M_IDLE, 1'b0);
   endtask

   task automatic rise(input bit sda, input logic [4:0] strb, input logic [1:0] mode_after);
      ev(1'b0, 1'b0, 1'b1, 1'b0, sda, strb, mode_after, 1'b1);
   endtask

   task automatic fall(input logic [4:0] strb, input logic [1:0] mode_after);
      ev(1'b0, 1'b0, 1'b0, 1'b1, sda_in, strb, mode_after, 1'b1);
   endtask

   task automatic idle_edges();
      ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, S_NONE, M_IDLE, 1'b0);
      ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, S_NONE, M_IDLE, 1'b0);
   endtask

   task automatic rst_ev();
      rst      = 1'b1;
      scl_fall = 1'b1;
      exp_strb = S_NONE;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      scl_fall = 1'b0;
      exp_mode = M_IDLE;
      exp_busy = 1'b0;
      gap();
   endtask

   // Address byte up to the master's rise in the ACK slot
   task automatic send_addr(input logic [7:0] ab, output bit ok);
      fall(S_NONE, M_IDLE);
      for (int k = 1; k <= 8; k++) begin
         rise(ab[3'(8 - k)], S_RX, M_IDLE);
         if (k < 8) fall(S_NONE, M_IDLE);
      end
      ok = (ab[7:1] == 7'h3C) || (GC_EN && ab == 8'h00);
      fall(S_NONE, ok ? M_ACK : M_NACK);
      rise(1'b0, S_NONE, ok ? M_ACK : M_NACK);
   endtask

   // Falling edge that closes the address ACK/NACK slot
   task automatic addr_exit(input bit ok, input bit rw, input bit empty);
      if (ok && rw) begin
         tx_empty = empty;
         fall(S_LD | (empty ? S_NONE : S_RD), M_TX);
      end else begin
         fall(S_NONE, M_IDLE);
      end
   endtask

   // Master-written byte; abort_at>0 issues a repeated START after that many bits
   task automatic rx_byte(input logic [7:0] d, input int abort_at, input bit full,
                          output bit acked, output bit aborted);
      aborted = 1'b0;
      acked   = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         rise(d[3'(8 - k)], S_RX, M_IDLE);
         if (k == abort_at) begin
            aborted = 1'b1;
            break;
         end
         if (k < 8) fall(S_NONE, M_IDLE);
      end
      if (aborted) begin
         do_start();
      end else begin
         rx_full = full;
         fall(full ? S_NONE : S_WR, full ? M_NACK : M_ACK);
         rise(1'b0, S_NONE, full ? M_NACK : M_ACK);
         fall(S_NONE, M_IDLE);
         rx_full = 1'b0;
         acked   = !full;
      end
   endtask

   // Slave-transmitted byte and master ACK/NACK; rst_at>0 resets after that many bits
   task automatic tx_byte(input bit nack, input bit empty, input int rst_at);
      bit hit;
      hit = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         rise(1'b1, S_NONE, M_TX);
         if (k == rst_at) begin
            hit = 1'b1;
            break;
         end
         if (k < 8) fall(S_TX, M_TX);
      end
      if (hit) begin
         rst_ev();
      end else begin
         fall(S_NONE, M_IDLE);
         rise(nack, S_NONE, M_IDLE);
         if (!nack) begin
            tx_empty = empty;
            fall(S_LD | (empty ? S_NONE : S_RD), M_TX);
         end else begin
            fall(S_NONE, M_IDLE);
         end
      end
   endtask

   initial begin
      bit         ok;
      bit         acked;
      bit         aborted;
      bit         pend_start;
      bit         nack;
      int         nb;
      int         b_rx;
      int         b_tx;
      int         b_ld;
      int         b_rd;
      int         b_wr;
      logic [7:0] ab;

      rst         = 1'b1;
      start_found = 1'b0;
      stop_found  = 1'b0;
      scl_rise    = 1'b0;
      scl_fall    = 1'b0;
      sda_in      = 1'b1;
      rx_data     = 8'h00;
      tx_empty    = 1'b0;
      rx_full     = 1'b0;
      exp_strb    = S_NONE;
      exp_mode    = M_IDLE;
      exp_busy    = 1'b0;
      @(posedge clk);
      #1;
      checking = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      gap();

      // Write 0x78 then data 0xA5
      b_rx = cnt_rxs; b_wr = cnt_wr;
      do_start();
      send_addr(8'h78, ok);
      chk("addr_ack_mode", 32'(sda_mode), 32'(2'b01));
      addr_exit(ok, 1'b0, 1'b0);
      rx_byte(8'hA5, 0, 1'b0, acked, aborted);
      chk("rx_model_data", 32'(rx_data), 32'(8'hA5));
      do_stop();
      chk("write_rx_shift_cnt", 32'(cnt_rxs - b_rx), 32'd16);
      chk("write_rx_write_cnt", 32'(cnt_wr - b_wr), 32'd1);
      chk("write_busy_after_stop", 32'(busy), 32'd0);

      // Read 0x79: master ACKs byte 1, NACKs byte 2
      b_txs_blk: begin
         b_tx = cnt_txs; b_ld = cnt_ld; b_rd = cnt_rd;
      end
      do_start();
      send_addr(8'h79, ok);
      addr_exit(ok, 1'b1, 1'b0);
      chk("read_tx_mode", 32'(sda_mode), 32'(2'b11));
      tx_byte(1'b0, 1'b0, 0);
      tx_byte(1'b1, 1'b0, 0);
      chk("read_wait_stop_busy", 32'(busy), 32'd1);
      do_stop();
      chk("read_tx_shift_cnt", 32'(cnt_txs - b_tx), 32'd14);
      chk("read_load_cnt", 32'(cnt_ld - b_ld), 32'd2);
      chk("read_tx_read_cnt", 32'(cnt_rd - b_rd), 32'd2);

      // Mismatched address 0x52
      b_wr = cnt_wr;
      do_start();
      send_addr(8'h52, ok);
      chk("mismatch_nack_mode", 32'(sda_mode), 32'(2'b10));
      addr_exit(ok, 1'b0, 1'b0);
      rise(1'b0, S_NONE, M_IDLE);
      fall(S_NONE, M_IDLE);
      chk("mismatch_busy", 32'(busy), 32'd1);
      do_stop();
      chk("mismatch_rx_write_cnt", 32'(cnt_wr - b_wr), 32'd0);

      // Write into a full RX FIFO, then read from an empty TX FIFO
      b_wr = cnt_wr; b_ld = cnt_ld; b_rd = cnt_rd;
      do_start();
      send_addr(8'h78, ok);
      addr_exit(ok, 1'b0, 1'b0);
      rx_byte(8'h3C, 0, 1'b1, acked, aborted);
      do_stop();
      do_start();
      send_addr(8'h79, ok);
      addr_exit(ok, 1'b1, 1'b1);
      tx_byte(1'b1, 1'b0, 0);
      do_stop();
      tx_empty = 1'b0;
      chk("full_rx_write_cnt", 32'(cnt_wr - b_wr), 32'd0);
      chk("empty_load_cnt", 32'(cnt_ld - b_ld), 32'd1);
      chk("empty_tx_read_cnt", 32'(cnt_rd - b_rd), 32'd0);

      // Repeated START after bit 3 of a data byte, then reset mid TX byte
      b_wr = cnt_wr;
      do_start();
      send_addr(8'h78, ok);
      addr_exit(ok, 1'b0, 1'b0);
      rx_byte(8'hF0, 3, 1'b0, acked, aborted);
      send_addr(8'h79, ok);
      addr_exit(ok, 1'b1, 1'b0);
      tx_byte(1'b0, 1'b0, 2);
      chk("rs_rx_write_cnt", 32'(cnt_wr - b_wr), 32'd0);
      chk("post_reset_mode", 32'(sda_mode), 32'(2'b00));
      chk("post_reset_busy", 32'(busy), 32'd0);

      // General call
      do_start();
      send_addr(8'h00, ok);
      chk("gcall_mode", 32'(sda_mode), GC_EN ? 32'(2'b01) : 32'(2'b10));
      addr_exit(ok, 1'b0, 1'b0);
      if (ok) rx_byte(8'h5A, 0, 1'b0, acked, aborted);
      do_stop();

      // Random traffic
      pend_start = 1'b0;
      for (int t = 0; t < 40; t++) begin
         case ($urandom_range(0, 4))
            0:       ab = 8'h78;
            1:       ab = 8'h79;
            2:       ab = 8'h00;
            default: ab = 8'($urandom);
         endcase
         if (!pend_start) do_start();
         pend_start = 1'b0;
         send_addr(ab, ok);
         addr_exit(ok, ab[0], $urandom_range(0, 3) == 0);
         nb = $urandom_range(1, 3);
         if (!ok) begin
            rise(1'b0, S_NONE, M_IDLE);
            fall(S_NONE, M_IDLE);
         end else if (!ab[0]) begin
            for (int b = 0; b < nb; b++) begin
               rx_byte(8'($urandom), ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 7)) : 0,
                       $urandom_range(0, 4) == 0, acked, aborted);
               if (aborted) begin
                  pend_start = 1'b1;
                  break;
               end
               if (!acked) break;
            end
         end else begin
            for (int b = 0; b < nb; b++) begin
               nack = (b == nb - 1) || ($urandom_range(0, 5) == 0);
               tx_byte(nack, $urandom_range(0, 3) == 0, 0);
               if (nack) break;
            end
         end
         if (!pend_start) begin
            do_stop();
            if ($urandom_range(0, 1) == 1) idle_edges();
         end
      end
      do_stop();

      checking = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/i2c_slave_ctrl.md
Name: i2c_slave_ctrl

Overview:
- Byte-level sequencer for the I2C slave. Tracks START/STOP framing, counts bits and matches the 7-bit address.
- Drives the 2-bit SDA-mode select to the SDA output selector (IDLE/ACK/NACK/TX_OUT).
- Issues shift/load/FIFO strobes to the RX shift register, TX shift register, RX FIFO and TX FIFO.
- Sits between the SCL/SDA edge detectors and the byte datapath.

Parameters:
- SLAVE_ADDR, 7'h3C, 7-bit address this slave acknowledges.
- BYTE_BITS, 8, data bits per byte before the ACK slot.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start_found  input  1  one-clk pulse: START or repeated START detected.
- stop_found  input  1  one-clk pulse: STOP detected.
- scl_rise  input  1  one-clk pulse: synchronized SCL rising edge.
- scl_fall  input  1  one-clk pulse: synchronized SCL falling edge.
- sda_in  input  1  synchronized SDA level.
- rx_data  input  8  RX shift register contents (MSB first; [0] = R/W during address byte).
- tx_empty  input  1  TX FIFO empty.
- rx_full  input  1  RX FIFO full.
- sda_mode  output  2  00 IDLE, 01 ACK, 10 NACK, 11 TX_OUT.
- rx_shift  output  1  RX shift-register enable pulse.
- tx_shift  output  1  TX shift-register shift pulse.
- load_data  output  1  TX shift-register parallel-load pulse.
- tx_read  output  1  TX FIFO pop pulse.
- rx_write  output  1  RX FIFO push pulse.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst high at a clk edge):
  - state IDLE, bit_cnt 0, rw 0.
  - sda_mode 00; all pulse outputs 0; busy 0.
  - Reset mid-transfer aborts immediately, with no further strobes.
- sda_mode is a Moore decode of state. Strobes are Mealy, asserted in the same clk as the qualifying scl_* pulse. No extra latency.
- States and sda_mode:
  - IDLE (00), ADDR (00), ADDR_CHK (00), ACK_SLOT (01), NACK_SLOT (10), RX_BYTE (00), TX_BYTE (11), MACK (00), WAIT_STOP (00).
- Global priority, applied every clk:
  1. stop_found → IDLE.
  2. start_found → ADDR with bit_cnt 0. Applies from any state, including repeated START mid-byte.
  - Both asserted in the same clk: stop wins.
- ADDR:
  - Each scl_rise: rx_shift=1, bit_cnt++.
  - When bit_cnt reaches BYTE_BITS → ADDR_CHK.
- ADDR_CHK (one clk):
  - Latch rw=rx_data[0] and match=(rx_data[7:1]==SLAVE_ADDR).
  - Clear bit_cnt.
  - Wait for scl_fall, then → ACK_SLOT if match, else → NACK_SLOT and flag "no match".
- ACK_SLOT / NACK_SLOT:
  - Mode held from entry scl_fall through the following scl_fall. On that exit scl_fall:
    - No-match NACK → WAIT_STOP.
    - Address ACK with rw=0 → RX_BYTE.
    - Address ACK with rw=1 → TX_BYTE, with load_data=1 in the same clk; tx_read=1 only if !tx_empty.
    - Data ACK after RX → RX_BYTE.
    - Data NACK caused by rx_full → WAIT_STOP.
- RX_BYTE:
  - Each scl_rise: rx_shift=1, bit_cnt++.
  - After the BYTE_BITS-th rise, on the next scl_fall:
    - If !rx_full: rx_write=1, → ACK_SLOT.
    - Else → NACK_SLOT, no push.
- TX_BYTE:
  - Each scl_rise: bit_cnt++.
  - Each scl_fall while bit_cnt in 1..BYTE_BITS-1: tx_shift=1.
  - At scl_fall with bit_cnt==BYTE_BITS → MACK, bit_cnt cleared.
- MACK:
  - On scl_rise, latch sda_in.
  - On the following scl_fall:
    - Latched 0 (master ACK): load_data=1, tx_read=!tx_empty, → TX_BYTE.
    - Latched 1 (master NACK): → WAIT_STOP.
- Empty TX FIFO: load still pulses and the FIFO data path supplies 8'hFF. The controller never pops an empty FIFO.
- WAIT_STOP: sda_mode 00; leaves only via the global STOP/START rules.
- bit_cnt: 4-bit, saturates at BYTE_BITS, never wraps.
- scl_rise and scl_fall are never asserted in the same clk (guaranteed by the source). If they are, scl_rise is processed and scl_fall is ignored.

Optional Feature:
- Macro: I2C_GENERAL_CALL_EN.
- Defined: in ADDR_CHK, rx_data[7:0]==8'h00 also sets match (rw=0 write path). All subsequent behaviour is as for the slave's own address.
- Undefined: address 0x00 is NACKed like any mismatch.

Decomposition:
- Package i2c_pkg holds:
  - typedef enum logic [1:0] sda_mode_t {SDA_IDLE=2'b00, SDA_ACK=2'b01, SDA_NACK=2'b10, SDA_TX=2'b11};
  - typedef enum ctrl_state_t with the nine states above;
  - constant BYTE_BITS_DEF=8.
- One sub-module, i2c_bit_counter: clear, count_en, saturating terminal-count flag.

Test Plan:
- START, address 0x78 (0x3C<<1|0), data byte 0xA5, STOP → 8 rx_shift; sda_mode 01 during the address ACK; 8 rx_shift; rx_write pulse; sda_mode 01; IDLE after STOP; busy 0.
- START, address 0x79, master ACKs the first byte, NACKs the second → load_data+tx_read ×2; sda_mode 11 during bytes, 00 in MACK; 7 tx_shift per byte; WAIT_STOP after the NACK.
- Address 0x52 (mismatch) → sda_mode 10 for one SCL pulse; no rx_write; WAIT_STOP; busy 1 until STOP.
- Write with rx_full=1 at the end of the data byte → NACK_SLOT, no rx_write; read with tx_empty=1 → load_data=1, tx_read=0.
- Repeated START after bit 3 of the data byte → ADDR, bit_cnt 0, no rx_write. Then rst pulse mid-TX_BYTE → next clk sda_mode 00, all strobes 0.
- General call 0x00 with I2C_GENERAL_CALL_EN defined → ACK; undefined → NACK.
